// File: rtl/mux_pipe_rr_pkg.sv
// Shared types and defaults for the N-to-1 pipelined selector.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 8;

  // Increment a channel index, wrapping to 0 at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_pipe_rr_if.sv
// Producer/consumer bundle around the selector: N input channels, one output channel.
interface mux_pipe_rr_if
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN
) ();
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  mux_mode_e               mode;
  logic [SEL_W-1:0]        select;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_src, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_src, out_valid, sel_err
  );
endinterface

// File: rtl/mux_pipe_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping at NUM_IN.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);
  localparam logic [SEL_W:0] NUM_W = (SEL_W+1)'(NUM_IN);

  logic [2*NUM_IN-1:0] req_dbl;
  logic [NUM_IN-1:0]   rot;
  logic [SEL_W-1:0]    pos;
  logic [SEL_W:0]      sum;
  logic                found;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    req_dbl = {req, req};
    rot     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rot[i] = req_dbl[32'(ptr) + i];
    end
    found = 1'b0;
    pos   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        pos   = SEL_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= NUM_W) sum = sum - NUM_W;
    gnt_idx = sum[SEL_W-1:0];
    gnt     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (enable && found && gnt_idx == SEL_W'(i)) gnt[i] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_pipe_rr.sv
// N-to-1 selector (explicit or round-robin) with a one-deep valid/ready output register.
module mux_pipe_rr
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN
) (
  input  logic         clk,
  input  logic         reset,
  mux_pipe_rr_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              can_accept;
  logic              sel_ok;
  logic              xfer;
  logic [NUM_IN-1:0] rdy;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;

  logic [WIDTH-1:0]  data_p1;
  logic [SEL_W-1:0]  src_p1;
  logic              vld_p1;
  logic              err_p1;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .enable  (bus.mode == MODE_RR),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  assign can_accept = !vld_p1 || bus.out_ready;
  assign sel_ok     = {1'b0, bus.select} < NUM_IN_L;

  // Stage p0: grant selection and handshake; ready never looks at held data.
  always_comb begin
    rdy       = '0;
    grant_idx = rr_idx;
    if (bus.mode == MODE_SEL) begin
      grant_idx = bus.select;
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel_ok && bus.select == SEL_W'(i)) rdy[i] = 1'b1;
      end
    end else begin
      rdy = rr_gnt;
    end
    if (reset || !can_accept) rdy = '0;
  end

  assign xfer = |(rdy & bus.in_valid);

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Stage p1: output register, round-robin pointer and select-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p1 <= '0;
      src_p1  <= '0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      if (xfer) begin
        data_p1 <= grant_data;
        src_p1  <= grant_idx;
        vld_p1  <= 1'b1;
      end else if (bus.out_ready) begin
        vld_p1  <= 1'b0;
      end
      if (xfer && bus.mode == MODE_RR) begin
        rr_ptr <= SEL_W'(wrap_inc(32'(rr_idx), 32'(NUM_IN)));
      end
      err_p1 <= (bus.mode == MODE_SEL) && !sel_ok && (|bus.in_valid);
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.out_valid = vld_p1;
  assign bus.sel_err   = err_p1;

endmodule

// File: tb/tb_mux_pipe_rr.sv
// Bench for mux_pipe_rr: an 8-input and a 5-input instance share stimulus and a behavioural model.
module tb_mux_pipe_rr;
  import mux_pkg::*;

  logic         clk;
  logic         reset;
  logic [255:0] data_all;
  logic [7:0]   vin;
  logic [2:0]   sel;
  mux_mode_e    mode;
  logic         out_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic        m_vld [2];
  logic [31:0] m_data[2];
  logic [2:0]  m_src [2];
  logic [2:0]  m_ptr [2];
  logic        m_err [2];
  logic [7:0]  exp_rdy[2];

  mux_pipe_rr_if #(.WIDTH(32), .NUM_IN(8)) ifa ();
  mux_pipe_rr_if #(.WIDTH(32), .NUM_IN(5)) ifb ();

  assign ifa.in_data   = data_all;
  assign ifa.in_valid  = vin;
  assign ifa.mode      = mode;
  assign ifa.select    = sel;
  assign ifa.out_ready = out_ready;
  assign ifb.in_data   = data_all[159:0];
  assign ifb.in_valid  = vin[4:0];
  assign ifb.mode      = mode;
  assign ifb.select    = sel;
  assign ifb.out_ready = out_ready;

  mux_pipe_rr #(.WIDTH(32), .NUM_IN(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mux_pipe_rr #(.WIDTH(32), .NUM_IN(5)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 1'b0; m_data[d] = '0; m_src[d] = '0; m_ptr[d] = '0; m_err[d] = 1'b0;
    end
  endtask

  // Expected ready vector from the selection rules, for the current inputs.
  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      int  n;
      bit  can, found;
      n = (d == 0) ? 8 : 5;
      exp_rdy[d] = '0;
      if (!reset) begin
        can = !m_vld[d] || out_ready;
        if (mode == MODE_SEL) begin
          if (int'(sel) < n && can) exp_rdy[d][sel] = 1'b1;
        end else begin
          found = 0;
          for (int k = 0; k < n; k++) begin
            int j;
            j = (int'(m_ptr[d]) + k) % n;
            if (!found && vin[j]) begin
              found = 1;
              if (can) exp_rdy[d][j] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    if (reset) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        int n, x;
        bit any_v;
        n = (d == 0) ? 8 : 5;
        x = -1;
        any_v = 0;
        for (int j = 0; j < n; j++) begin
          if (exp_rdy[d][j] && vin[j]) x = j;
          if (vin[j]) any_v = 1;
        end
        if (x >= 0) begin
          m_vld[d]  = 1'b1;
          m_data[d] = data_all[x*32 +: 32];
          m_src[d]  = 3'(x);
          if (mode == MODE_RR) m_ptr[d] = 3'((x + 1) % n);
        end else if (out_ready) begin
          m_vld[d] = 1'b0;
        end
        m_err[d] = (mode == MODE_SEL) && (int'(sel) >= n) && any_v;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("A.in_ready",  32'(ifa.in_ready),  32'(exp_rdy[0]));
    check_eq("A.out_valid", 32'(ifa.out_valid), 32'(m_vld[0]));
    check_eq("A.out_data",  ifa.out_data,       m_data[0]);
    check_eq("A.out_src",   32'(ifa.out_src),   32'(m_src[0]));
    check_eq("A.sel_err",   32'(ifa.sel_err),   32'(m_err[0]));
    check_eq("B.in_ready",  32'(ifb.in_ready),  32'(exp_rdy[1]));
    check_eq("B.out_valid", 32'(ifb.out_valid), 32'(m_vld[1]));
    check_eq("B.out_data",  ifb.out_data,       m_data[1]);
    check_eq("B.out_src",   32'(ifb.out_src),   32'(m_src[1]));
    check_eq("B.sel_err",   32'(ifb.sel_err),   32'(m_err[1]));
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    check_outputs();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    vin       = '0;
    sel       = '0;
    mode      = MODE_SEL;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) data_all[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
    model_reset();

    // Reset state
    cycle();
    cycle();
    check_eq("rst.out_valid", 32'(ifa.out_valid), 32'd0);
    check_eq("rst.out_data",  ifa.out_data,       32'd0);
    check_eq("rst.in_ready",  32'(ifa.in_ready),  32'd0);
    reset = 1'b0;

    // Explicit select sweep
    out_ready = 1'b1;
    vin       = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      check_eq("sel.data", ifa.out_data, 32'h1111_1111 * 32'(s + 1));
      check_eq("sel.src",  32'(ifa.out_src), 32'(s));
    end

    // Round-robin over all channels, then over ch2/ch5
    mode = MODE_RR;
    for (int k = 0; k < 9; k++) begin
      cycle();
      check_eq("rr.all.src", 32'(ifa.out_src), 32'(k % 8));
    end
    vin = 8'h24;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("rr.pair.src", 32'(ifa.out_src), (k % 2 == 0) ? 32'd2 : 32'd5);
    end

    // Backpressure
    vin = 8'h00;
    cycle();
    vin = 8'hFF;
    out_ready = 1'b0;
    cycle();
    check_eq("bp.load.data", ifa.out_data, 32'h4444_4444);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("bp.stall.valid", 32'(ifa.out_valid), 32'd1);
      check_eq("bp.stall.data",  ifa.out_data,       32'h4444_4444);
      check_eq("bp.stall.ready", 32'(ifa.in_ready),  32'd0);
    end
    out_ready = 1'b1;
    cycle();
    check_eq("bp.release.valid", 32'(ifa.out_valid), 32'd1);
    check_eq("bp.release.src",   32'(ifa.out_src),   32'd4);
    check_eq("bp.release.data",  ifa.out_data,       32'h5555_5555);

    // Out-of-range select on the 5-channel instance, then RR wrap 4 -> 0
    mode = MODE_SEL;
    sel  = 3'd6;
    vin  = 8'h01;
    cycle();
    check_eq("err.pulse",    32'(ifb.sel_err),  32'd1);
    check_eq("err.in_ready", 32'(ifb.in_ready), 32'd0);
    vin = 8'h00;
    cycle();
    check_eq("err.clear", 32'(ifb.sel_err), 32'd0);
    mode = MODE_RR;
    vin  = 8'h10;
    cycle();
    check_eq("wrap.src4", 32'(ifb.out_src), 32'd4);
    vin = 8'h11;
    cycle();
    check_eq("wrap.src0", 32'(ifb.out_src), 32'd0);

    // Asynchronous reset mid-stream
    vin = 8'hFF;
    cycle();
    cycle();
    check_eq("arst.pre.valid", 32'(ifa.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst.valid",    32'(ifa.out_valid), 32'd0);
    check_eq("arst.data",     ifa.out_data,       32'd0);
    check_eq("arst.src",      32'(ifa.out_src),   32'd0);
    check_eq("arst.in_ready", 32'(ifa.in_ready),  32'd0);
    check_eq("arst.b.valid",  32'(ifb.out_valid), 32'd0);
    model_reset();
    cycle();
    reset = 1'b0;
    cycle();
    check_eq("arst.restart.a", 32'(ifa.out_src), 32'd0);
    check_eq("arst.restart.b", 32'(ifb.out_src), 32'd0);

    // Mode switch while stalled: RR ptr=3 -> SEL select=7 -> back to RR
    cycle();
    cycle();
    check_eq("sw.pre.src", 32'(ifa.out_src), 32'd2);
    out_ready = 1'b0;
    cycle();
    mode = MODE_SEL;
    sel  = 3'd7;
    cycle();
    check_eq("sw.held.src",   32'(ifa.out_src),   32'd2);
    check_eq("sw.held.data",  ifa.out_data,       32'h3333_3333);
    check_eq("sw.held.valid", 32'(ifa.out_valid), 32'd1);
    out_ready = 1'b1;
    cycle();
    check_eq("sw.sel7.src",  32'(ifa.out_src), 32'd7);
    check_eq("sw.sel7.data", ifa.out_data,     32'h8888_8888);
    mode = MODE_RR;
    cycle();
    check_eq("sw.resume.src", 32'(ifa.out_src), 32'd3);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) data_all[i*32 +: 32] = $urandom;
      vin       = 8'($urandom);
      sel       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = (mode == MODE_RR) ? MODE_SEL : MODE_RR;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
